// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - header-decoded frame loader feeding matrix/vector buffers and MVM start/done handshake
module rx_frame_ctrl #(
  parameter int W_IN    = 16,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_valid,
  input  logic [W_IN-1:0]   s_data,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [W_IN-1:0]   mem_wdata,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]   T_MAX = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [3:0] OP_LOAD_MAT = 4'd1;
  localparam logic [3:0] OP_LOAD_VEC = 4'd2;
  localparam logic [3:0] OP_START    = 4'd3;

  localparam logic [1:0] E_HEADER  = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_DROP    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                sel_q, sel_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [W_IN-1:0]     wdata_q, wdata_d;
  logic                start_q, start_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic [3:0]          hdr_op;
  logic [ADDR_W:0]     hdr_len;
  logic                hdr_load_ok;

  assign hdr_op      = s_data[W_IN-1 -: 4];
  assign hdr_len     = s_data[ADDR_W:0];
  assign hdr_load_ok = ((hdr_op == OP_LOAD_MAT) || (hdr_op == OP_LOAD_VEC)) &&
                       (hdr_len != '0) && (hdr_len <= N_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      tcnt_q     <= '0;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      tcnt_q     <= tcnt_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      start_q    <= start_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    tcnt_d     = tcnt_q;
    sel_d      = sel_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    start_d    = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          if (hdr_load_ok) begin
            state_d = S_LOAD;
            addr_d  = '0;
            rem_d   = hdr_len;
            tcnt_d  = '0;
            sel_d   = (hdr_op == OP_LOAD_VEC);
          end else if (hdr_op == OP_START) begin
            state_d = S_RUN;
            start_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = E_HEADER;
          end
        end
      end

      S_LOAD: begin
        // A word arriving on the last allowed idle cycle still wins over the timeout.
        if (s_valid) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = s_data;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          tcnt_d  = '0;
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = S_IDLE;
          end
        end else if (tcnt_q == T_MAX) begin
          state_d    = S_IDLE;
          tcnt_d     = '0;
          err_d      = 1'b1;
          err_code_d = E_TIMEOUT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      S_RUN: begin
        state_d = S_WAIT;
        if (s_valid) begin
          err_d      = 1'b1;
          err_code_d = E_DROP;
        end
      end

      S_WAIT: begin
        if (s_valid) begin
          err_d      = 1'b1;
          err_code_d = E_DROP;
        end
        if (done) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_we    = we_q;
  assign mem_sel   = sel_q;
  assign mem_addr  = waddr_q;
  assign mem_wdata = wdata_q;
  assign start     = start_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - directed self-checking bench for rx_frame_ctrl
module tb_rx_frame_ctrl;

  localparam int TMO = 16;

  logic        clk;
  logic        rstn;
  logic        s_valid;
  logic [15:0] s_data;
  logic        done;

  logic        mem_we, mem_sel, start, busy, err;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  err_code;

  logic        mem_we_s, mem_sel_s, start_s, busy_s, err_s;
  logic [1:0]  mem_addr_s;
  logic [15:0] mem_wdata_s;
  logic [1:0]  err_code_s;

  int checks = 0;
  int errors = 0;

  rx_frame_ctrl #(.W_IN(16), .ADDR_W(10), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .start(start), .done(done), .busy(busy), .err(err), .err_code(err_code)
  );

  rx_frame_ctrl #(.W_IN(16), .ADDR_W(2), .TIMEOUT(TMO)) dut_small (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
    .mem_we(mem_we_s), .mem_sel(mem_sel_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
    .start(start_s), .done(done), .busy(busy_s), .err(err_s), .err_code(err_code_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    s_valid = 1'b1;
    s_data  = w;
    tick();
    s_valid = 1'b0;
    s_data  = 16'h0;
  endtask

  initial begin
    logic [15:0] words [3];
    words[0] = 16'hAAAA;
    words[1] = 16'hBBBB;
    words[2] = 16'hCCCC;

    rstn = 1'b0; s_valid = 1'b0; s_data = 16'h0; done = 1'b0;
    repeat (3) tick();
    check("rst_we",    mem_we,    0);
    check("rst_addr",  mem_addr,  0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_sel",   mem_sel,   0);
    check("rst_busy",  busy,      0);
    check("rst_start", start,     0);
    check("rst_err",   err,       0);
    check("rst_code",  err_code,  0);
    rstn = 1'b1;
    tick();

    // three-word matrix load
    send(16'h1003);
    check("l3_hdr_busy", busy, 1);
    check("l3_hdr_we",   mem_we, 0);
    for (int i = 0; i < 3; i++) begin
      send(words[i]);
      check($sformatf("l3_we%0d", i),   mem_we,    1);
      check($sformatf("l3_addr%0d", i), mem_addr,  i);
      check($sformatf("l3_data%0d", i), mem_wdata, words[i]);
      check($sformatf("l3_sel%0d", i),  mem_sel,   0);
      check($sformatf("l3_busy%0d", i), busy,      (i == 2) ? 0 : 1);
    end
    tick();
    check("l3_we_drop", mem_we, 0);

    // bad headers, then a one-word vector load
    send(16'h2000);
    check("n0_err",  err,      1);
    check("n0_code", err_code, 1);
    check("n0_busy", busy,     0);
    tick();
    check("n0_err_pulse", err,      0);
    check("n0_code_hold", err_code, 1);
    send(16'h5001);
    check("badop_err",  err,  1);
    check("badop_busy", busy, 0);
    send(16'h1401);
    check("bigN_err",  err,  1);
    check("bigN_busy", busy, 0);
    send(16'h2001);
    check("v1_busy", busy,    1);
    check("v1_sel",  mem_sel, 1);
    check("v1_err",  err,     0);
    send(16'h1234);
    check("v1_we",   mem_we,    1);
    check("v1_addr", mem_addr,  0);
    check("v1_data", mem_wdata, 16'h1234);
    check("v1_busy_end", busy,  0);

    // timeout: a word on the last idle cycle is accepted, a full idle window times out
    send(16'h1002);
    repeat (TMO - 1) tick();
    check("to_edge_busy", busy, 1);
    send(16'h0101);
    check("to_edge_we",   mem_we,   1);
    check("to_edge_err",  err,      0);
    check("to_edge_busy2", busy,    1);
    repeat (TMO - 1) tick();
    check("to_pre_err",  err,  0);
    check("to_pre_busy", busy, 1);
    tick();
    check("to_err",  err,      1);
    check("to_code", err_code, 2);
    check("to_busy", busy,     0);
    send(16'h2001);
    check("to_next_hdr_we",  mem_we,  0);
    check("to_next_hdr_sel", mem_sel, 1);
    send(16'h5555);
    check("to_next_we",   mem_we,   1);
    check("to_next_addr", mem_addr, 0);

    // compute start, dropped word in WAIT, done
    send(16'h3000);
    check("run_start", start, 1);
    check("run_busy",  busy,  1);
    tick();
    check("run_start_pulse", start, 0);
    check("wait_busy",       busy,  1);
    send(16'h7777);
    check("drop_err",  err,      1);
    check("drop_code", err_code, 3);
    check("drop_we",   mem_we,   0);
    check("drop_busy", busy,     1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("done_busy", busy, 0);

    // async reset mid-load
    send(16'h1004);
    send(16'h1111);
    send(16'h2222);
    check("ar_we",   mem_we,   1);
    check("ar_addr", mem_addr, 1);
    #1 rstn = 1'b0;
    #1;
    check("ar_we0",    mem_we,    0);
    check("ar_addr0",  mem_addr,  0);
    check("ar_data0",  mem_wdata, 0);
    check("ar_busy0",  busy,      0);
    check("ar_code0",  err_code,  0);
    tick();
    rstn = 1'b1;
    tick();
    check("ar_nowrite", mem_we, 0);
    send(16'h2001);
    check("ar_hdr_we",   mem_we,  0);
    check("ar_hdr_busy", busy,    1);
    check("ar_hdr_sel",  mem_sel, 1);
    send(16'h9999);
    check("ar_post_we",   mem_we,    1);
    check("ar_post_addr", mem_addr,  0);
    check("ar_post_data", mem_wdata, 16'h9999);

    // full-depth load with ADDR_W=2
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    send(16'h1004);
    check("s_hdr_busy", busy_s, 1);
    check("s_hdr_err",  err_s,  0);
    for (int i = 0; i < 4; i++) begin
      send(16'h4000 + 16'(i));
      check($sformatf("s_we%0d", i),   mem_we_s,    1);
      check($sformatf("s_addr%0d", i), mem_addr_s,  i);
      check($sformatf("s_data%0d", i), mem_wdata_s, 16'h4000 + i);
      check($sformatf("s_err%0d", i),  err_s,       0);
      check($sformatf("s_busy%0d", i), busy_s,      (i == 3) ? 0 : 1);
    end
    tick();
    check("s_we_drop", mem_we_s,   0);
    check("s_code",    err_code_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter W_IN, default 16, meaning received word width, matching the UART receiver output.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning buffer address width, so at most 2^ADDR_W words per load.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning the maximum idle clocks allowed between payload words.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 s_valid  input  1  one-cycle pulse per received word; there is no back-pressure.
REQ-007 s_data  input  W_IN  received word, valid only while s_valid=1.
REQ-008 mem_we  output  1  buffer write strobe.
REQ-009 mem_sel  output  1  write target: 0 = matrix buffer, 1 = vector buffer.
REQ-010 mem_addr  output  ADDR_W  buffer write address.
REQ-011 mem_wdata  output  W_IN  buffer write data.
REQ-012 start  output  1  one-cycle compute-start pulse to the MVM core.
REQ-013 done  input  1  one-cycle compute-complete pulse from the MVM core.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err  output  1  one-cycle error pulse.
REQ-016 err_code  output  2  code of the last error: 1 = bad header, 2 = timeout, 3 = word dropped.

Function
REQ-017 SHALL implement the states IDLE, LOAD, RUN and WAIT.
REQ-018 Header word format SHALL be: s_data[W_IN-1:W_IN-4] = opcode; s_data[ADDR_W:0] = length N.
REQ-019 Opcode values SHALL be: 1 = load matrix, 2 = load vector, 3 = start compute; all other opcodes are invalid.
REQ-020 In IDLE, a header with opcode 1 or 2 and 1<=N<=2^ADDR_W SHALL go to LOAD with address counter = 0, remaining count = N, mem_sel = opcode-1 and timeout counter = 0.
REQ-021 In IDLE, a header with opcode 3 SHALL go to RUN; the value of N is ignored.
REQ-022 In IDLE, an invalid opcode, or N=0, or N>2^ADDR_W on a load opcode SHALL pulse err with err_code=1 and stay in IDLE.
REQ-023 In LOAD, each s_valid SHALL produce mem_we=1 on the next cycle, with mem_wdata = that word, mem_addr = address counter and mem_sel as latched; latency is exactly 1 clock.
REQ-024 After each LOAD write the address SHALL increment, remaining count SHALL decrement and the timeout counter SHALL clear.
REQ-025 The address SHALL wrap only when N=2^ADDR_W, and only after the last word.
REQ-026 On the write of the Nth word, the block SHALL return to IDLE in the same cycle that mem_we is high for that word.
REQ-027 In LOAD, the timeout counter SHALL increment on each cycle without s_valid.
REQ-028 When the timeout counter reaches TIMEOUT-1 without s_valid, the block SHALL pulse err with err_code=2 and go to IDLE; words already written stay written.
REQ-029 If s_valid arrives in the cycle the timeout counter reaches TIMEOUT-1, the word SHALL be accepted and no timeout SHALL be raised.
REQ-030 RUN SHALL last one cycle with start=1, then go to WAIT.
REQ-031 WAIT SHALL go to IDLE on the cycle after done=1; done seen in any other state SHALL be ignored.
REQ-032 s_valid in RUN or WAIT SHALL discard the word and pulse err with err_code=3; the state SHALL be unchanged.
REQ-033 mem_we, start and err SHALL be registered, single-cycle pulses; mem_we=0 outside LOAD writes.
REQ-034 err_code SHALL hold its value until the next error or reset.

Reset
REQ-035 While rstn=0, the block SHALL force state=IDLE, all counters=0 and all outputs=0, including mem_addr, mem_wdata, mem_sel and err_code.
REQ-036 Reset asserted mid-LOAD or mid-WAIT SHALL abandon the operation with no further mem_we or start pulses.
REQ-037 After rstn rises, the first s_valid SHALL be decoded as a header.

Verification
REQ-038 Header 0x1003, then words 0xAAAA, 0xBBBB, 0xCCCC -> three mem_we pulses at addr 0,1,2, sel=0, data as sent, each 1 clock after its s_valid; busy drops after the third write.
REQ-039 Header 0x2000 -> err pulse, err_code=1, busy stays 0; then header 0x2001 + 0x1234 -> one write at addr 0, sel=1.
REQ-040 Header 0x1002 + one word, then no input for TIMEOUT cycles -> err, err_code=2, state IDLE; the next word is treated as a header.
REQ-041 Header 0x3000 -> start pulse 1 clock later, busy=1; s_valid during WAIT -> err_code=3 and no write; done -> busy=0 the next cycle.
REQ-042 Header 0x1004, two words, rstn pulsed low asynchronously -> all outputs 0 immediately, no further writes, and the next word is decoded as a header.
REQ-043 With ADDR_W=2, header 0x1004 + four words -> addresses 0..3, no error, and return to IDLE.
